// File: rtl/lsu_pkg.sv
// Shared constants, entry layout and latency predictor for the LSU load scheduler.
package lsu_pkg;

    localparam int HIT_LAT_DEF   = 2;
    localparam int MISS_LAT_DEF  = 100;
    localparam int LSU_DEPTH_DEF = 4;
    localparam int ROB_W_DEF     = 4;
    localparam int CNT_W_DEF     = $clog2(MISS_LAT_DEF + 1);

    typedef struct packed {
        logic                 valid;
        logic [14:0]          pc;
        logic [15:0]          va;
        logic [ROB_W_DEF-1:0] rob;
        logic [CNT_W_DEF-1:0] cnt;
    } lq_entry_t;

    // PCs with bits [2:1] clear are predicted to miss
    function automatic logic predict_miss(input logic [14:0] pc);
        return (pc[2:1] == 2'b00);
    endfunction

endpackage

// File: rtl/lsu_age_matrix.sv
// Age matrix: row i bit j set means entry i is older than entry j; grants the oldest requester.
module lsu_age_matrix #(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DEPTH-1:0] valid_vec,
    input  logic [DEPTH-1:0] alloc_vec,
    input  logic [DEPTH-1:0] free_vec,
    input  logic [DEPTH-1:0] req_vec,
    output logic [DEPTH-1:0] grant_vec
);

    logic [DEPTH-1:0] r_age [DEPTH];
    logic [DEPTH-1:0] w_blocked;

    // A new entry is younger than every live entry; a freed entry stops claiming seniority
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_age[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                for (int j = 0; j < DEPTH; j++) begin
                    if (i == j) begin
                        r_age[i][j] <= 1'b0;
                    end else if (alloc_vec[i]) begin
                        r_age[i][j] <= 1'b0;
                    end else if (alloc_vec[j]) begin
                        r_age[i][j] <= valid_vec[i];
                    end else if (free_vec[i]) begin
                        r_age[i][j] <= 1'b0;
                    end else begin
                        r_age[i][j] <= r_age[i][j];
                    end
                end
            end
        end
    end

    always_comb begin
        w_blocked = '0;
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                w_blocked[i] = w_blocked[i] | (req_vec[j] & r_age[j][i]);
            end
        end
        grant_vec = req_vec & ~w_blocked;
    end

endmodule

// File: rtl/lsu_load_scheduler.sv
// Load queue with latency prediction, out-of-order completion and oldest-first
// serialisation onto the single read port and ROB writeback port.
module lsu_load_scheduler
    import lsu_pkg::*;
#(
    parameter int DEPTH    = LSU_DEPTH_DEF,
    parameter int HIT_LAT  = HIT_LAT_DEF,
    parameter int MISS_LAT = MISS_LAT_DEF,
    parameter int ROB_W    = ROB_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [14:0]              in_pc,
    input  logic [15:0]              in_va,
    input  logic [ROB_W-1:0]         in_rob_index,
    input  logic                     flush,
    output logic [15:0]              mem_addr,
    input  logic [15:0]              mem_rdata,
    output logic                     out_valid,
    output logic [ROB_W-1:0]         out_rob_index,
    output logic [15:0]              out_return_value,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int OCC_W = IDX_W + 1;
    localparam int CNT_W = CNT_W_DEF;

    lq_entry_t          r_q [DEPTH];
    logic [OCC_W-1:0]   r_occ;
    logic [15:0]        r_mem_addr;
    logic               r_out_valid;
    logic [ROB_W-1:0]   r_out_rob;
    logic [15:0]        r_out_val;

    logic [DEPTH-1:0]   w_valid;
    logic [DEPTH-1:0]   w_req;
    logic [DEPTH-1:0]   w_grant;
    logic [DEPTH-1:0]   w_alloc_vec;
    logic [DEPTH-1:0]   w_free_vec;
    logic [IDX_W-1:0]   w_free_idx;
    logic [IDX_W-1:0]   w_sel_idx;
    logic               w_alloc;
    logic               w_sel;
    logic               w_unused_pc;

    always_comb begin
        w_valid     = '0;
        w_req       = '0;
        w_free_idx  = '0;
        w_sel_idx   = '0;
        w_unused_pc = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            w_valid[i]  = r_q[i].valid;
            w_req[i]    = r_q[i].valid && (r_q[i].cnt == '0);
            w_sel_idx   = w_sel_idx | (w_grant[i] ? IDX_W'(i) : '0);
            w_unused_pc = w_unused_pc ^ (^r_q[i].pc);
        end
        // Scan downward so the lowest free index wins
        for (int i = DEPTH - 1; i >= 0; i--) begin
            w_free_idx = w_valid[i] ? w_free_idx : IDX_W'(i);
        end
    end

    assign in_ready    = !rst && (r_occ < OCC_W'(DEPTH));
    assign w_alloc     = in_valid && in_ready && !flush;
    assign w_alloc_vec = w_alloc ? (DEPTH'(1) << w_free_idx) : '0;
    assign w_sel       = (|w_grant) && !rst && !flush;
    assign w_free_vec  = w_sel ? w_grant : '0;
    assign mem_addr    = w_sel ? r_q[w_sel_idx].va : r_mem_addr;

    lsu_age_matrix #(
        .DEPTH (DEPTH)
    ) u_age (
        .clk       (clk),
        .rst       (rst),
        .valid_vec (w_valid),
        .alloc_vec (w_alloc_vec),
        .free_vec  (w_free_vec),
        .req_vec   (w_req),
        .grant_vec (w_grant)
    );

    // Entry array: allocate, free on select, otherwise count down toward zero
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_q[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_q[i].valid <= 1'b0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_alloc_vec[i]) begin
                    r_q[i].valid <= 1'b1;
                    r_q[i].pc    <= in_pc;
                    r_q[i].va    <= in_va;
                    r_q[i].rob   <= ROB_W_DEF'(in_rob_index);
                    r_q[i].cnt   <= predict_miss(in_pc) ? CNT_W'(MISS_LAT) : CNT_W'(HIT_LAT);
                end else if (w_free_vec[i]) begin
                    r_q[i].valid <= 1'b0;
                end else if (r_q[i].valid && (r_q[i].cnt != '0)) begin
                    r_q[i].cnt <= r_q[i].cnt - CNT_W'(1);
                end else begin
                    r_q[i] <= r_q[i];
                end
            end
        end
    end

    // Occupancy, held read address and writeback registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_occ       <= '0;
            r_mem_addr  <= 16'h0000;
            r_out_valid <= 1'b0;
            r_out_rob   <= '0;
            r_out_val   <= 16'h0000;
        end else if (flush) begin
            r_occ       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_occ       <= r_occ + OCC_W'(w_alloc) - OCC_W'(w_sel);
            r_out_valid <= w_sel;
            if (w_sel) begin
                r_mem_addr <= r_q[w_sel_idx].va;
                r_out_rob  <= ROB_W'(r_q[w_sel_idx].rob);
                r_out_val  <= mem_rdata;
            end else begin
                r_mem_addr <= r_mem_addr;
            end
        end
    end

    assign out_valid        = r_out_valid;
    assign out_rob_index    = r_out_rob;
    assign out_return_value = r_out_val;
    assign occupancy        = r_occ;

endmodule

// File: tb/tb_lsu_load_scheduler.sv
// Scenario tasks plus a randomized run checked against a queue-based reference model.
module tb_lsu_load_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [14:0] in_pc;
    logic [15:0] in_va;
    logic [3:0]  in_rob_index;
    logic        flush;
    logic [15:0] mem_addr;
    logic [15:0] mem_rdata;
    logic        out_valid;
    logic [3:0]  out_rob_index;
    logic [15:0] out_return_value;
    logic [2:0]  occupancy;

    int n_checks = 0;
    int n_fail   = 0;

    int          tnow;
    int          wb_t[$];
    logic [3:0]  wb_rob[$];
    logic [15:0] wb_val[$];

    lsu_load_scheduler dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_pc            (in_pc),
        .in_va            (in_va),
        .in_rob_index     (in_rob_index),
        .flush            (flush),
        .mem_addr         (mem_addr),
        .mem_rdata        (mem_rdata),
        .out_valid        (out_valid),
        .out_rob_index    (out_rob_index),
        .out_return_value (out_return_value),
        .occupancy        (occupancy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_fn(input logic [15:0] a);
        if (a == 16'h1234) return 16'hBEEF;
        return {a[7:0], a[15:8]} ^ 16'hA5C3;
    endfunction

    assign mem_rdata = mem_fn(mem_addr);

    // Reference model: in-flight loads kept in age order, each with the edge at which it may write back
    typedef struct {
        logic [3:0]  rob;
        logic [15:0] va;
        int          wb_edge;
    } ld_t;

    ld_t         mq[$];
    ld_t         m_new;
    int          m_edge = 0;
    int          m_pick;
    bit          m_can;
    logic        m_ov  = 1'b0;
    logic [3:0]  m_rob = 4'h0;
    logic [15:0] m_val = 16'h0000;

    initial forever begin
        @(posedge clk);
        m_edge = m_edge + 1;
        if (rst) begin
            mq.delete();
            m_ov = 1'b0; m_rob = 4'h0; m_val = 16'h0000;
        end else if (flush) begin
            mq.delete();
            m_ov = 1'b0;
        end else begin
            m_can  = (mq.size() < 4);
            m_pick = -1;
            foreach (mq[i]) if (m_pick < 0 && mq[i].wb_edge <= m_edge) m_pick = i;
            m_ov = (m_pick >= 0);
            if (m_pick >= 0) begin
                m_rob = mq[m_pick].rob;
                m_val = mem_fn(mq[m_pick].va);
                mq.delete(m_pick);
            end
            if (in_valid && m_can) begin
                m_new.rob     = in_rob_index;
                m_new.va      = in_va;
                m_new.wb_edge = m_edge + ((in_pc[2:1] == 2'b00) ? 100 : 2) + 1;
                mq.push_back(m_new);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_rec();
        tick();
        tnow++;
        if (out_valid === 1'b1) begin
            wb_t.push_back(tnow);
            wb_rob.push_back(out_rob_index);
            wb_val.push_back(out_return_value);
        end
    endtask

    task automatic clear_rec();
        wb_t.delete(); wb_rob.delete(); wb_val.delete();
        tnow = -1;
    endtask

    task automatic drive(input logic [14:0] pc, input logic [15:0] va, input logic [3:0] rob);
        in_valid = 1'b1; in_pc = pc; in_va = va; in_rob_index = rob;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0;
        drive(15'h0002, 16'h1111, 4'h5);
        repeat (2) tick();
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (occupancy !== 3'd0) begin n_fail++; $display("FAIL reset_occupancy: got %0d expected 0", occupancy); end
        n_checks++; if (out_rob_index !== 4'h0) begin n_fail++; $display("FAIL reset_rob: got %0d expected 0", out_rob_index); end
        n_checks++; if (out_return_value !== 16'h0000) begin n_fail++; $display("FAIL reset_value: got %h expected 0000", out_return_value); end
        n_checks++; if (mem_addr !== 16'h0000) begin n_fail++; $display("FAIL reset_mem_addr: got %h expected 0000", mem_addr); end
        rst = 1'b0; idle();
        tick();
        n_checks++; if (occupancy !== 3'd0) begin n_fail++; $display("FAIL reset_no_alloc: got %0d expected 0", occupancy); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_single_hit();
        clear_rec();
        drive(15'h0002, 16'h1234, 4'h3);
        tick_rec();
        idle();
        n_checks++; if (occupancy !== 3'd1) begin n_fail++; $display("FAIL hit_occ_after_accept: got %0d expected 1", occupancy); end
        repeat (6) tick_rec();
        n_checks++; if (wb_t.size() != 1) begin n_fail++; $display("FAIL hit_count: got %0d expected 1", wb_t.size()); end
        n_checks++; if ((wb_t.size() > 0 ? wb_t[0] : -1) != 3) begin n_fail++; $display("FAIL hit_latency: got %0d expected 3", (wb_t.size() > 0 ? wb_t[0] : -1)); end
        n_checks++; if ((wb_rob.size() > 0 ? wb_rob[0] : 4'hx) !== 4'h3) begin n_fail++; $display("FAIL hit_rob: got %0d expected 3", (wb_rob.size() > 0 ? wb_rob[0] : 4'hx)); end
        n_checks++; if ((wb_val.size() > 0 ? wb_val[0] : 16'hxxxx) !== 16'hBEEF) begin n_fail++; $display("FAIL hit_value: got %h expected beef", (wb_val.size() > 0 ? wb_val[0] : 16'hxxxx)); end
        n_checks++; if (mem_addr !== 16'h1234) begin n_fail++; $display("FAIL hit_mem_addr_hold: got %h expected 1234", mem_addr); end
        n_checks++; if (occupancy !== 3'd0) begin n_fail++; $display("FAIL hit_occ_drained: got %0d expected 0", occupancy); end
    endtask

    task automatic test_miss_overtaken();
        int          exp_t[2]   = '{4, 101};
        logic [3:0]  exp_rob[2] = '{4'h2, 4'h1};
        logic [15:0] exp_val[2];
        exp_val[0] = mem_fn(16'h0200);
        exp_val[1] = mem_fn(16'h0100);
        clear_rec();
        drive(15'h0000, 16'h0100, 4'h1); tick_rec();
        drive(15'h0006, 16'h0200, 4'h2); tick_rec();
        idle();
        repeat (106) tick_rec();
        n_checks++; if (wb_t.size() != 2) begin n_fail++; $display("FAIL miss_count: got %0d expected 2", wb_t.size()); end
        for (int k = 0; k < 2; k++) begin
            n_checks++; if ((wb_t.size() > k ? wb_t[k] : -1) != exp_t[k]) begin n_fail++; $display("FAIL miss_time[%0d]: got %0d expected %0d", k, (wb_t.size() > k ? wb_t[k] : -1), exp_t[k]); end
            n_checks++; if ((wb_rob.size() > k ? wb_rob[k] : 4'hx) !== exp_rob[k]) begin n_fail++; $display("FAIL miss_rob[%0d]: got %0d expected %0d", k, (wb_rob.size() > k ? wb_rob[k] : 4'hx), exp_rob[k]); end
            n_checks++; if ((wb_val.size() > k ? wb_val[k] : 16'hxxxx) !== exp_val[k]) begin n_fail++; $display("FAIL miss_value[%0d]: got %h expected %h", k, (wb_val.size() > k ? wb_val[k] : 16'hxxxx), exp_val[k]); end
        end
    endtask

    task automatic test_back_to_back();
        int          exp_t[4]   = '{101, 102, 103, 104};
        logic [3:0]  exp_rob[4] = '{4'h8, 4'h9, 4'hA, 4'hB};
        clear_rec();
        drive(15'h0010, 16'h2000, 4'h8); tick_rec();
        idle();
        while (tnow < 97) tick_rec();
        drive(15'h0002, 16'h2001, 4'h9); tick_rec();
        drive(15'h0004, 16'h2002, 4'hA); tick_rec();
        drive(15'h0006, 16'h2003, 4'hB); tick_rec();
        idle();
        repeat (8) tick_rec();
        n_checks++; if (wb_t.size() != 4) begin n_fail++; $display("FAIL tie_count: got %0d expected 4", wb_t.size()); end
        for (int k = 0; k < 4; k++) begin
            n_checks++; if ((wb_t.size() > k ? wb_t[k] : -1) != exp_t[k]) begin n_fail++; $display("FAIL tie_time[%0d]: got %0d expected %0d", k, (wb_t.size() > k ? wb_t[k] : -1), exp_t[k]); end
            n_checks++; if ((wb_rob.size() > k ? wb_rob[k] : 4'hx) !== exp_rob[k]) begin n_fail++; $display("FAIL tie_rob[%0d]: got %0d expected %0d", k, (wb_rob.size() > k ? wb_rob[k] : 4'hx), exp_rob[k]); end
            n_checks++; if ((wb_val.size() > k ? wb_val[k] : 16'hxxxx) !== mem_fn(16'h2000 + 16'(k))) begin n_fail++; $display("FAIL tie_value[%0d]: got %h expected %h", k, (wb_val.size() > k ? wb_val[k] : 16'hxxxx), mem_fn(16'h2000 + 16'(k))); end
        end
    endtask

    task automatic test_full();
        int acc_t   = -1;
        int max_occ = 0;
        clear_rec();
        for (int i = 0; i < 4; i++) begin
            drive(15'h0008, 16'h3000 + 16'(i), 4'(i));
            tick_rec();
        end
        drive(15'h0002, 16'h4000, 4'h4);
        n_checks++; if (occupancy !== 3'd4) begin n_fail++; $display("FAIL full_occ: got %0d expected 4", occupancy); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready: got %b expected 0", in_ready); end
        while (tnow < 110) begin
            if (in_valid && in_ready) acc_t = tnow + 1;
            tick_rec();
            if (acc_t >= 0) idle();
            if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
        end
        n_checks++; if (acc_t != 102) begin n_fail++; $display("FAIL full_resume_edge: got %0d expected 102", acc_t); end
        n_checks++; if (max_occ != 4) begin n_fail++; $display("FAIL full_max_occ: got %0d expected 4", max_occ); end
        n_checks++; if (wb_t.size() != 5) begin n_fail++; $display("FAIL full_count: got %0d expected 5", wb_t.size()); end
        for (int k = 0; k < 5; k++) begin
            n_checks++; if ((wb_t.size() > k ? wb_t[k] : -1) != 101 + k) begin n_fail++; $display("FAIL full_time[%0d]: got %0d expected %0d", k, (wb_t.size() > k ? wb_t[k] : -1), 101 + k); end
            n_checks++; if ((wb_rob.size() > k ? wb_rob[k] : 4'hx) !== 4'(k)) begin n_fail++; $display("FAIL full_rob[%0d]: got %0d expected %0d", k, (wb_rob.size() > k ? wb_rob[k] : 4'hx), k); end
        end
    endtask

    task automatic test_flush();
        clear_rec();
        drive(15'h0002, 16'h5000, 4'h1); tick_rec();
        drive(15'h0004, 16'h5001, 4'h2); tick_rec();
        drive(15'h0006, 16'h5002, 4'h3); tick_rec();
        flush = 1'b1;
        drive(15'h0002, 16'h6000, 4'h4);
        tick_rec();
        flush = 1'b0; idle();
        n_checks++; if (occupancy !== 3'd0) begin n_fail++; $display("FAIL flush_occ: got %0d expected 0", occupancy); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready: got %b expected 1", in_ready); end
        repeat (8) tick_rec();
        drive(15'h0002, 16'h7000, 4'h5); tick_rec();
        idle();
        repeat (6) tick_rec();
        n_checks++; if (wb_t.size() != 1) begin n_fail++; $display("FAIL flush_wb_count: got %0d expected 1", wb_t.size()); end
        n_checks++; if ((wb_t.size() > 0 ? wb_t[0] : -1) != 15) begin n_fail++; $display("FAIL flush_new_time: got %0d expected 15", (wb_t.size() > 0 ? wb_t[0] : -1)); end
        n_checks++; if ((wb_rob.size() > 0 ? wb_rob[0] : 4'hx) !== 4'h5) begin n_fail++; $display("FAIL flush_new_rob: got %0d expected 5", (wb_rob.size() > 0 ? wb_rob[0] : 4'hx)); end
        n_checks++; if ((wb_val.size() > 0 ? wb_val[0] : 16'hxxxx) !== mem_fn(16'h7000)) begin n_fail++; $display("FAIL flush_new_value: got %h expected %h", (wb_val.size() > 0 ? wb_val[0] : 16'hxxxx), mem_fn(16'h7000)); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            rst      = ($urandom_range(0, 299) == 0);
            flush    = ($urandom_range(0, 79) == 0);
            in_valid = ($urandom_range(0, 2) != 0);
            in_pc    = 15'($urandom);
            in_va    = 16'($urandom);
            in_rob_index = 4'($urandom);
            tick();
            n_checks++; if (out_valid !== m_ov) begin n_fail++; $display("FAIL rand_out_valid c=%0d: got %b expected %b", c, out_valid, m_ov); end
            n_checks++; if (out_rob_index !== m_rob) begin n_fail++; $display("FAIL rand_rob c=%0d: got %0d expected %0d", c, out_rob_index, m_rob); end
            n_checks++; if (out_return_value !== m_val) begin n_fail++; $display("FAIL rand_value c=%0d: got %h expected %h", c, out_return_value, m_val); end
            n_checks++; if (occupancy !== 3'(mq.size())) begin n_fail++; $display("FAIL rand_occ c=%0d: got %0d expected %0d", c, occupancy, mq.size()); end
            n_checks++; if (in_ready !== (!rst && mq.size() < 4)) begin n_fail++; $display("FAIL rand_in_ready c=%0d: got %b expected %b", c, in_ready, (!rst && mq.size() < 4)); end
        end
        rst = 1'b0; flush = 1'b0; idle();
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
        in_pc = 15'h0000; in_va = 16'h0000; in_rob_index = 4'h0;
        test_reset();
        test_single_hit();
        test_miss_overtaken();
        test_back_to_back();
        test_full();
        test_flush();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
